// File: rtl/l2_fwd_responder.sv
// l2_fwd_responder: answers L2 forward requests (LOAD/STORE/INV_FWD) with a local
// line lookup and a FWDACK; define PMESH_FWDACK_DATA_EN to append dirty line data.
module l2_fwd_responder #(
    parameter int unsigned FWD_LEN_MIN = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] chipid,
    input  logic [7:0]  coreid_x,
    input  logic [7:0]  coreid_y,
    input  logic        noc2_valid_in,
    input  logic [63:0] noc2_data_in,
    output logic        noc2_ready_in,
    output logic        noc3_valid_out,
    output logic [63:0] noc3_data_out,
    input  logic        noc3_ready_out,
    output logic        lkp_req,
    output logic [1:0]  lkp_op,
    output logic [39:0] lkp_addr,
    input  logic        lkp_dirty,
    input  logic [63:0] lkp_data
);
    localparam int unsigned FLIT_W = 64;
    localparam int unsigned ADDR_W = 40;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned TYPE_W = 8;
    localparam int unsigned ID_W   = 30;
    localparam logic [LEN_W-1:0]  LEN_MIN      = LEN_W'(FWD_LEN_MIN);
    localparam logic [TYPE_W-1:0] LOAD_FWD     = 8'd16;
    localparam logic [TYPE_W-1:0] STORE_FWD    = 8'd17;
    localparam logic [TYPE_W-1:0] INV_FWD      = 8'd18;
    localparam logic [TYPE_W-1:0] LOAD_FWDACK  = 8'd24;
    localparam logic [TYPE_W-1:0] STORE_FWDACK = 8'd25;
    localparam logic [TYPE_W-1:0] INV_FWDACK   = 8'd26;
    localparam logic [1:0]        OP_DOWNGRADE  = 2'd0;
    localparam logic [1:0]        OP_INVALIDATE = 2'd1;

    typedef struct packed {
        logic [ID_W-1:0]   dst;
        logic [3:0]        fbits;
        logic [LEN_W-1:0]  len;
        logic [TYPE_W-1:0] mtype;
        logic [7:0]        mshr;
        logic [5:0]        opts;
    } hdr_t;

    typedef struct packed {
        logic [ID_W-1:0]        id;
        logic [FLIT_W-ID_W-1:0] rsvd;
    } id_flit_t;

    typedef enum logic [3:0] {
        IDLE, RX_ADDR, RX_SRC, RX_DRAIN, LOOKUP, LK_WAIT,
        TX_HDR, TX_ADDR, TX_SRC, TX_DATA, DISCARD
    } state_t;

    state_t              state_q, state_d;
    logic [TYPE_W-1:0]   mtype_q, mtype_d;
    logic [7:0]          mshr_q, mshr_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ID_W-1:0]     src_q, src_d;
    logic                wdata_q, wdata_d;
    logic                valid_d;
    logic [FLIT_W-1:0]   odata_d;
    logic                lkp_req_d;
    logic [1:0]          lkp_op_d;
    logic [ADDR_W-1:0]   lkp_addr_d;
    logic [FLIT_W-1:0]   fwd_data;
    logic                accept;
    logic                go_lookup;
    logic                unused_bits;
    hdr_t                hdr_in;
    hdr_t                hdr_out;
    id_flit_t            id_in;
    id_flit_t            own_id;

    function automatic logic is_fwd(input logic [TYPE_W-1:0] t);
        return (t == LOAD_FWD) || (t == STORE_FWD) || (t == INV_FWD);
    endfunction

    function automatic logic [TYPE_W-1:0] ack_type(input logic [TYPE_W-1:0] t);
        logic [TYPE_W-1:0] a;
        a = INV_FWDACK;
        case (t)
            LOAD_FWD:  a = LOAD_FWDACK;
            STORE_FWD: a = STORE_FWDACK;
            default:   a = INV_FWDACK;
        endcase
        return a;
    endfunction

    assign hdr_in  = noc2_data_in;
    assign id_in   = noc2_data_in;
    assign own_id  = '{id: {chipid, coreid_x, coreid_y}, rsvd: '0};
    assign accept  = noc2_valid_in && noc2_ready_in;

    // Ready is a pure state decode, forced low while reset is held.
    assign noc2_ready_in = rst_n && (state_q inside {IDLE, RX_ADDR, RX_SRC, RX_DRAIN, DISCARD});

`ifdef PMESH_FWDACK_DATA_EN
    logic [FLIT_W-1:0] ldata_q, ldata_d;
    assign fwd_data    = ldata_q;
    assign unused_bits = ^{hdr_in.dst, hdr_in.fbits, hdr_in.opts, id_in.rsvd};
`else
    assign fwd_data    = '0;
    assign unused_bits = ^{hdr_in.dst, hdr_in.fbits, hdr_in.opts, id_in.rsvd, lkp_dirty, lkp_data};
`endif

    // State and registered-output update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            mtype_q        <= '0;
            mshr_q         <= '0;
            rem_q          <= '0;
            addr_q         <= '0;
            src_q          <= '0;
            wdata_q        <= 1'b0;
            noc3_valid_out <= 1'b0;
            noc3_data_out  <= '0;
            lkp_req        <= 1'b0;
            lkp_op         <= '0;
            lkp_addr       <= '0;
`ifdef PMESH_FWDACK_DATA_EN
            ldata_q        <= '0;
`endif
        end else begin
            state_q        <= state_d;
            mtype_q        <= mtype_d;
            mshr_q         <= mshr_d;
            rem_q          <= rem_d;
            addr_q         <= addr_d;
            src_q          <= src_d;
            wdata_q        <= wdata_d;
            noc3_valid_out <= valid_d;
            noc3_data_out  <= odata_d;
            lkp_req        <= lkp_req_d;
            lkp_op         <= lkp_op_d;
            lkp_addr       <= lkp_addr_d;
`ifdef PMESH_FWDACK_DATA_EN
            ldata_q        <= ldata_d;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        mtype_d    = mtype_q;
        mshr_d     = mshr_q;
        rem_d      = rem_q;
        addr_d     = addr_q;
        src_d      = src_q;
        wdata_d    = wdata_q;
        valid_d    = noc3_valid_out;
        odata_d    = noc3_data_out;
        lkp_req_d  = 1'b0;
        lkp_op_d   = '0;
        lkp_addr_d = '0;
        go_lookup  = 1'b0;
        hdr_out    = '0;
`ifdef PMESH_FWDACK_DATA_EN
        ldata_d    = ldata_q;
`endif
        if (accept && state_q != IDLE) begin
            rem_d = (rem_q != '0) ? rem_q - LEN_W'(1) : '0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    mtype_d = hdr_in.mtype;
                    mshr_d  = hdr_in.mshr;
                    rem_d   = hdr_in.len;
                    if (hdr_in.len == '0) begin
                        state_d = IDLE;
                    end else if (is_fwd(hdr_in.mtype) && hdr_in.len >= LEN_MIN) begin
                        state_d = RX_ADDR;
                    end else begin
                        state_d = DISCARD;
                    end
                end
            end
            RX_ADDR: begin
                if (accept) begin
                    addr_d = noc2_data_in[ADDR_W-1:0];
                    if (rem_q == LEN_W'(1)) go_lookup = 1'b1;
                    else                    state_d   = RX_SRC;
                end
            end
            RX_SRC: begin
                if (accept) begin
                    src_d = id_in.id;
                    if (rem_q == LEN_W'(1)) go_lookup = 1'b1;
                    else                    state_d   = RX_DRAIN;
                end
            end
            RX_DRAIN: begin
                if (accept && rem_q == LEN_W'(1)) go_lookup = 1'b1;
            end
            LOOKUP: state_d = LK_WAIT;
            LK_WAIT: begin
`ifdef PMESH_FWDACK_DATA_EN
                wdata_d = lkp_dirty && (mtype_q != INV_FWD);
                ldata_d = lkp_data;
`else
                wdata_d = 1'b0;
`endif
                hdr_out.dst   = src_q;
                hdr_out.len   = wdata_d ? LEN_W'(3) : LEN_W'(2);
                hdr_out.mtype = ack_type(mtype_q);
                hdr_out.mshr  = mshr_q;
                valid_d = 1'b1;
                odata_d = hdr_out;
                state_d = TX_HDR;
            end
            TX_HDR: begin
                if (noc3_ready_out) begin
                    odata_d = FLIT_W'(addr_q);
                    state_d = TX_ADDR;
                end
            end
            TX_ADDR: begin
                if (noc3_ready_out) begin
                    odata_d = own_id;
                    state_d = TX_SRC;
                end
            end
            TX_SRC: begin
                if (noc3_ready_out) begin
                    if (wdata_q) begin
                        odata_d = fwd_data;
                        state_d = TX_DATA;
                    end else begin
                        valid_d = 1'b0;
                        odata_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            TX_DATA: begin
                if (noc3_ready_out) begin
                    valid_d = 1'b0;
                    odata_d = '0;
                    state_d = IDLE;
                end
            end
            DISCARD: begin
                if (accept && rem_q <= LEN_W'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Lookup is issued from the registered address of the completed request
        if (go_lookup) begin
            state_d    = LOOKUP;
            lkp_req_d  = 1'b1;
            lkp_addr_d = addr_d;
            lkp_op_d   = (mtype_q == LOAD_FWD) ? OP_DOWNGRADE : OP_INVALIDATE;
        end
    end
endmodule

// File: tb/tb_l2_fwd_responder.sv
// Self-checking bench for l2_fwd_responder: transaction-level model plus per-cycle
// compare; follows PMESH_FWDACK_DATA_EN when defined for the build.
module tb_l2_fwd_responder;
    localparam int unsigned FWD_LEN_MIN = 2;
    localparam logic [13:0] CHIP = 14'h1A5;
    localparam logic [7:0]  CX   = 8'h3C;
    localparam logic [7:0]  CY   = 8'h7E;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        noc2_valid_in;
    logic [63:0] noc2_data_in;
    logic        noc2_ready_in;
    logic        noc3_valid_out;
    logic [63:0] noc3_data_out;
    logic        noc3_ready_out;
    logic        lkp_req;
    logic [1:0]  lkp_op;
    logic [39:0] lkp_addr;
    logic        lkp_dirty;
    logic [63:0] lkp_data;

    l2_fwd_responder #(.FWD_LEN_MIN(FWD_LEN_MIN)) dut (
        .clk(clk), .rst_n(rst_n), .chipid(CHIP), .coreid_x(CX), .coreid_y(CY),
        .noc2_valid_in(noc2_valid_in), .noc2_data_in(noc2_data_in), .noc2_ready_in(noc2_ready_in),
        .noc3_valid_out(noc3_valid_out), .noc3_data_out(noc3_data_out), .noc3_ready_out(noc3_ready_out),
        .lkp_req(lkp_req), .lkp_op(lkp_op), .lkp_addr(lkp_addr),
        .lkp_dirty(lkp_dirty), .lkp_data(lkp_data)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Model state
    int          cyc = 0;
    bit          busy = 0;
    bit          rx_hdr = 1;
    bit          rx_fwd = 0;
    int          rx_rem = 0;
    int          rx_idx = 0;
    logic [7:0]  rx_type, rx_mshr;
    logic [39:0] rx_addr;
    logic [29:0] rx_src;
    int          exp_lkp_cyc = -1;
    int          exp_first_cyc = -1;
    logic [63:0] exp_q[$];
    logic [1:0]  exp_op;
    logic [39:0] exp_addr;
    bit          prev_stall = 0;
    logic [63:0] prev_data;
    // Observations
    int          lkp_cnt = 0, lkp_cyc = 0, ack_cnt = 0, ack_in_txn = 0, noc2_cnt = 0;
    int          final_req_cyc = 0, first_valid_cyc = -1, stall_cycles = 0;
    logic [1:0]  lkp_last_op;
    logic [63:0] ack_got[8];
    // Stimulus controls
    bit          cur_dirty = 0, txn_dirty = 0;
    logic [63:0] cur_data = '0, txn_data = '0;
    bit          rand_rdy = 1, arm_hold = 0, rdy_stop = 0, lk_pend = 0;
    int          hold_lo = 0, stop_at = -1;

    function automatic bit is_fwd(input logic [7:0] t);
        return t == 8'd16 || t == 8'd17 || t == 8'd18;
    endfunction

    function automatic logic [7:0] ack_of(input logic [7:0] t);
        return (t == 8'd16) ? 8'd24 : (t == 8'd17) ? 8'd25 : 8'd26;
    endfunction

    task automatic start_txn();
        bit wd;
`ifdef PMESH_FWDACK_DATA_EN
        wd = cur_dirty && rx_type != 8'd18;
`else
        wd = 0;
`endif
        txn_dirty = cur_dirty;
        txn_data  = cur_data;
        busy = 1;
        final_req_cyc = cyc;
        exp_lkp_cyc = cyc + 1;
        exp_first_cyc = cyc + 3;
        ack_in_txn = 0;
        first_valid_cyc = -1;
        stall_cycles = 0;
        exp_op = (rx_type == 8'd16) ? 2'd0 : 2'd1;
        exp_addr = rx_addr;
        exp_q.delete();
        exp_q.push_back({rx_src, 4'd0, wd ? 8'd3 : 8'd2, ack_of(rx_type), rx_mshr, 6'd0});
        exp_q.push_back({24'd0, rx_addr});
        exp_q.push_back({CHIP, CX, CY, 34'd0});
        if (wd) exp_q.push_back(cur_data);
    endtask

    // Compare process: checks all outputs every cycle against the model
    always @(negedge clk) begin
        if (!rst_n) begin
            busy = 0; rx_hdr = 1; exp_q.delete(); exp_lkp_cyc = -1; exp_first_cyc = -1;
            prev_stall = 0; ack_in_txn = 0;
        end else begin
            cyc++;
            chk("noc2_ready_in", 64'(noc2_ready_in), 64'(!busy));
            chk("lkp_req", 64'(lkp_req), 64'(cyc == exp_lkp_cyc));
            if (lkp_req) begin
                lkp_cnt++;
                lkp_cyc = cyc;
                lkp_last_op = lkp_op;
                chk("lkp_op", 64'(lkp_op), 64'(exp_op));
                chk("lkp_addr", 64'(lkp_addr), 64'(exp_addr));
            end
            chk("noc3_valid_out", 64'(noc3_valid_out),
                64'(busy && exp_first_cyc >= 0 && cyc >= exp_first_cyc));
            if (noc3_valid_out && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (prev_stall && noc3_valid_out) chk("noc3_stable", noc3_data_out, prev_data);
            if (noc3_valid_out && !noc3_ready_out) stall_cycles++;
            prev_stall = noc3_valid_out && !noc3_ready_out;
            prev_data  = noc3_data_out;
            if (noc3_valid_out && noc3_ready_out && exp_q.size() > 0) begin
                chk("ack_flit", noc3_data_out, exp_q.pop_front());
                if (ack_in_txn < 8) ack_got[ack_in_txn] = noc3_data_out;
                ack_in_txn++;
                ack_cnt++;
                if (arm_hold && ack_in_txn == 1) begin hold_lo = 5; arm_hold = 0; end
                if (ack_in_txn == stop_at) rdy_stop = 1;
                if (exp_q.size() == 0) busy = 0;
            end
            if (noc2_valid_in && noc2_ready_in) begin
                noc2_cnt++;
                if (rx_hdr) begin
                    rx_type = noc2_data_in[21:14];
                    rx_mshr = noc2_data_in[13:6];
                    rx_rem  = int'(noc2_data_in[29:22]);
                    if (rx_rem != 0) begin
                        rx_hdr = 0;
                        rx_idx = 0;
                        rx_fwd = is_fwd(rx_type) && rx_rem >= int'(FWD_LEN_MIN);
                    end
                end else begin
                    rx_idx++;
                    if (rx_idx == 1) rx_addr = noc2_data_in[39:0];
                    if (rx_idx == 2) rx_src  = noc2_data_in[63:34];
                    rx_rem--;
                    if (rx_rem == 0) begin
                        rx_hdr = 1;
                        if (rx_fwd) start_txn();
                    end
                end
            end
        end
    end

    // Lookup responder: real result only in the cycle after lkp_req, noise otherwise
    always @(negedge clk) lk_pend = lkp_req;
    always @(posedge clk) begin
        #1;
        if (lk_pend) begin
            lkp_dirty = txn_dirty;
            lkp_data  = txn_data;
        end else begin
            lkp_dirty = 1'($urandom);
            lkp_data  = {$urandom, $urandom};
        end
    end

    // noc3 ready driver
    always @(posedge clk) begin
        #1;
        if (rdy_stop) noc3_ready_out = 1'b0;
        else if (hold_lo > 0) begin
            noc3_ready_out = 1'b0;
            hold_lo--;
        end else noc3_ready_out = rand_rdy ? 1'($urandom_range(0, 3) != 0) : 1'b1;
    end

    task automatic send_req(input logic [7:0] ty, input logic [7:0] len, input logic [7:0] mshr,
                            input logic [39:0] addr, input logic [29:0] src,
                            input bit dirty, input logic [63:0] data);
        logic [63:0] f;
        int g;
        cur_dirty = dirty;
        cur_data  = data;
        for (int i = 0; i <= int'(len); i++) begin
            if (i == 0)      f = {30'($urandom), 4'($urandom), len, ty, mshr, 6'($urandom)};
            else if (i == 1) f = {24'($urandom), addr};
            else if (i == 2) f = {src, 34'($urandom)};
            else             f = {$urandom, $urandom};
            repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
            noc2_valid_in = 1'b1;
            noc2_data_in  = f;
            g = 0;
            @(negedge clk);
            while (!noc2_ready_in && g < 300) begin @(negedge clk); g++; end
            @(posedge clk); #1;
            noc2_valid_in = 1'b0;
            noc2_data_in  = {$urandom, $urandom};
            if (g >= 300) begin
                tests++; fails++;
                $display("FAIL send_req_timeout: flit %0d never accepted", i);
                return;
            end
        end
    endtask

    task automatic wait_idle();
        int g = 0;
        while ((busy || !rx_hdr) && g < 1000) begin @(negedge clk); g++; end
        if (g >= 1000) begin
            tests++; fails++;
            $display("FAIL wait_idle_timeout: busy=%0d rx_hdr=%0d", busy, rx_hdr);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lb, ab, nb, g;
        logic [7:0] ty, len;
        rst_n = 1'b0; noc2_valid_in = 1'b0; noc2_data_in = '0;
        noc3_ready_out = 1'b0; lkp_dirty = 1'b0; lkp_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_noc2_ready", 64'(noc2_ready_in), 64'd0);
        chk("rst_noc3_valid", 64'(noc3_valid_out), 64'd0);
        chk("rst_noc3_data", noc3_data_out, 64'd0);
        chk("rst_lkp", 64'({lkp_req, lkp_op, lkp_addr}), 64'd0);
        @(posedge clk); #2; rst_n = 1'b1;
        @(posedge clk); #1;

        // LOAD_FWD clean: latency and header contents
        rand_rdy = 0;
        send_req(8'd16, 8'd2, 8'd5, 40'h12_3456_7840, {14'd0, 8'd1, 8'd2}, 0, 64'd0);
        wait_idle();
        chk("load_hdr", ack_got[0], 64'h0000_0408_0086_0140);
        chk("load_addr", ack_got[1], 64'h0000_0012_3456_7840);
        chk("load_src", ack_got[2], {CHIP, CX, CY, 34'd0});
        chk("load_nflits", 64'(ack_in_txn), 64'd3);
        chk("load_lkp_lat", 64'(lkp_cyc - final_req_cyc), 64'd1);
        chk("load_valid_lat", 64'(first_valid_cyc - final_req_cyc), 64'd3);
        chk("load_op", 64'(lkp_last_op), 64'd0);

        // STORE_FWD dirty
        send_req(8'd17, 8'd2, 8'd9, 40'hAB_CDEF_0120, {14'd3, 8'd4, 8'd5}, 1, 64'hDEAD_BEEF_CAFE_F00D);
        wait_idle();
        chk("store_op", 64'(lkp_last_op), 64'd1);
`ifdef PMESH_FWDACK_DATA_EN
        chk("store_nflits", 64'(ack_in_txn), 64'd4);
        chk("store_len", 64'(ack_got[0][29:22]), 64'd3);
        chk("store_data", ack_got[3], 64'hDEAD_BEEF_CAFE_F00D);
`else
        chk("store_nflits", 64'(ack_in_txn), 64'd3);
        chk("store_len", 64'(ack_got[0][29:22]), 64'd2);
`endif

        // INV_FWD len 4, dirty: extra flits drained, never carries data
        nb = noc2_cnt;
        send_req(8'd18, 8'd4, 8'd7, 40'h00_0000_1000, {14'd9, 8'd8, 8'd7}, 1, 64'h1234);
        wait_idle();
        chk("inv_consumed", 64'(noc2_cnt - nb), 64'd5);
        chk("inv_nflits", 64'(ack_in_txn), 64'd3);
        chk("inv_type", 64'(ack_got[0][21:14]), 64'd26);
        chk("inv_len", 64'(ack_got[0][29:22]), 64'd2);
        chk("inv_op", 64'(lkp_last_op), 64'd1);

        // Unknown type 31 len 3: discarded silently
        lb = lkp_cnt; ab = ack_cnt; nb = noc2_cnt;
        send_req(8'd31, 8'd3, 8'd1, 40'h5, 30'd1, 0, 64'd0);
        wait_idle();
        repeat (5) @(negedge clk);
        chk("disc_consumed", 64'(noc2_cnt - nb), 64'd4);
        chk("disc_no_lkp", 64'(lkp_cnt - lb), 64'd0);
        chk("disc_no_ack", 64'(ack_cnt - ab), 64'd0);
        @(posedge clk); #1;

        // Backpressure: 5 stalled cycles in the addr flit
        arm_hold = 1;
        send_req(8'd17, 8'd2, 8'd2, 40'h77_0000_0040, {14'd1, 8'd1, 8'd1}, 0, 64'd0);
        wait_idle();
        chk("hold_stalls", 64'(stall_cycles), 64'd5);
        chk("hold_nflits", 64'(ack_in_txn), 64'd3);
        chk("hold_addr", ack_got[1], 64'h0000_0077_0000_0040);

        // Reset while stalled in the source-ID flit
        stop_at = 2;
        send_req(8'd16, 8'd2, 8'd3, 40'h11_1111_1100, {14'd2, 8'd2, 8'd2}, 0, 64'd0);
        g = 0;
        while (ack_in_txn < 2 && g < 200) begin @(negedge clk); g++; end
        repeat (2) @(negedge clk);
        chk("pre_rst_valid", 64'(noc3_valid_out), 64'd1);
        chk("pre_rst_src", noc3_data_out, {CHIP, CX, CY, 34'd0});
        @(posedge clk); #2; rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(noc3_valid_out), 64'd0);
        chk("mid_rst_data", noc3_data_out, 64'd0);
        chk("mid_rst_ready", 64'(noc2_ready_in), 64'd0);
        repeat (2) @(posedge clk);
        #2; rst_n = 1'b1; rdy_stop = 0; stop_at = -1;
        @(posedge clk); #1;
        send_req(8'd16, 8'd2, 8'd6, 40'h22_2222_2200, {14'd4, 8'd4, 8'd4}, 0, 64'd0);
        wait_idle();
        chk("post_rst_nflits", 64'(ack_in_txn), 64'd3);
        chk("post_rst_hdr_mshr", 64'(ack_got[0][13:6]), 64'd6);

        // Randomized traffic
        rand_rdy = 1;
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: ty = 8'd16;
                3, 4:    ty = 8'd17;
                5, 6:    ty = 8'd18;
                default: ty = 8'($urandom_range(19, 255));
            endcase
            len = 8'($urandom_range(0, 5));
            send_req(ty, len, 8'($urandom), {$urandom, 8'($urandom)}, 30'($urandom),
                     1'($urandom), {$urandom, $urandom});
        end
        wait_idle();
        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
